// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM dead-time inserter.
package pwm_pkg;

    localparam int unsigned DT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        DT_IDLE,
        DT_DEAD,
        DT_HI,
        DT_LO
    } dt_state_e;

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter timing the dead interval; expire flags the last dead cycle.
module pwm_dt_counter
    import pwm_pkg::*;
#(
    parameter int unsigned DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    output logic            expire
);

    logic [DT_W-1:0] cnt_q, cnt_d;

    // Saturates at zero so a long idle period never wraps into a false expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == DT_W'(1));

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary gate-drive generator with dead-time insertion and fault/enable shutdown.
// Define PWM_DT_FAULT_LATCH_EN to make faults sticky until fault_clr.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int unsigned DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_cycles,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic            dead_active,
    output logic            fault_latched
);

    dt_state_e       state_q, state_d;
    logic            pwm_hi_q, pwm_hi_d;
    logic            pwm_lo_q, pwm_lo_d;
    logic            dead_q, dead_d;
    logic            fault_latched_q, fault_latched_d;
    logic            shutdown;
    logic            cnt_load;
    logic            cnt_expire;
    logic [DT_W-1:0] dead_len;

    assign dead_len = (dead_cycles == '0) ? DT_W'(1) : dead_cycles;

`ifdef PWM_DT_FAULT_LATCH_EN
    // A fault in the same cycle as a clear keeps the latch set.
    always_comb begin
        fault_latched_d = fault_latched_q;
        if (fault) begin
            fault_latched_d = 1'b1;
        end else if (fault_clr) begin
            fault_latched_d = 1'b0;
        end
    end
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
    assign fault_latched_d  = 1'b0;
`endif

    assign shutdown = ~en | fault | fault_latched_q;

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        if (shutdown) begin
            state_d = DT_IDLE;
        end else begin
            unique case (state_q)
                DT_IDLE: begin
                    state_d  = DT_DEAD;
                    cnt_load = 1'b1;
                end
                DT_DEAD: begin
                    if (cnt_expire) begin
                        state_d = pwm_in ? DT_HI : DT_LO;
                    end
                end
                DT_HI: begin
                    if (!pwm_in) begin
                        state_d  = DT_DEAD;
                        cnt_load = 1'b1;
                    end
                end
                DT_LO: begin
                    if (pwm_in) begin
                        state_d  = DT_DEAD;
                        cnt_load = 1'b1;
                    end
                end
                default: state_d = DT_IDLE;
            endcase
        end
        // Outputs decode the next state so they change on the same edge as the state.
        pwm_hi_d = (state_d == DT_HI);
        pwm_lo_d = (state_d == DT_LO);
        dead_d   = (state_d == DT_DEAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= DT_IDLE;
            pwm_hi_q        <= 1'b0;
            pwm_lo_q        <= 1'b0;
            dead_q          <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pwm_hi_q        <= pwm_hi_d;
            pwm_lo_q        <= pwm_lo_d;
            dead_q          <= dead_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    pwm_dt_counter #(
        .DT_W(DT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (dead_len),
        .expire   (cnt_expire)
    );

    assign pwm_hi        = pwm_hi_q;
    assign pwm_lo        = pwm_lo_q;
    assign dead_active   = dead_q;
    assign fault_latched = fault_latched_q;

endmodule
